// File: rtl/uart_event_reporter_pkg.sv
// Shared constants and types for the UART event reporter: FSM encodings,
// message selectors and the two fixed strings.
package uart_event_reporter_pkg;

  typedef enum logic [2:0] {
    ST_GUARD     = 3'd0,
    ST_LD_WEL    = 3'd1,
    ST_SEND_CHAR = 3'd2,
    ST_RDY_LOW   = 3'd3,
    ST_WAIT_RDY  = 3'd4,
    ST_IDLE      = 3'd5,
    ST_LD_BTN    = 3'd6
  } state_t;

  typedef enum logic {
    SEL_WEL = 1'b0,
    SEL_BTN = 1'b1
  } msg_sel_t;

  localparam int         WELCOME_LEN   = 31;
  localparam int         BTN_LEN       = 19;
  localparam logic [4:0] WELCOME_END   = 5'd31;
  localparam logic [4:0] BTN_END       = 5'd19;
  localparam logic [4:0] BTN_DIGIT_IDX = 5'd7;
  localparam logic [7:0] ASCII_0       = 8'h30;

  localparam logic [7:0] WELCOME_ROM [WELCOME_LEN] = '{
    8'h0A, 8'h0D,
    "A", "R", "T", "Y", " ", "G", "P", "I", "O", "/",
    "U", "A", "R", "T", " ", "D", "E", "M", "O", "!",
    " ", " ", " ", " ", " ", " ",
    8'h0A, 8'h0A, 8'h0D
  };

  // Byte 7 is unused here; the ROM substitutes the channel digit there.
  localparam logic [7:0] BTN_ROM [BTN_LEN] = '{
    "B", "u", "t", "t", "o", "n", " ", 8'h00,
    " ", "p", "r", "e", "s", "s", "e", "d", "!",
    8'h0A, 8'h0D
  };

endpackage

// File: rtl/uart_event_reporter_if.sv
// Byte-level SEND/DATA/READY handshake between the reporter and the UART
// transmitter.
interface uart_event_reporter_if;
  logic       TX_SEND;
  logic [7:0] TX_DATA;
  logic       TX_READY;

  modport master (output TX_SEND, output TX_DATA, input TX_READY);
  modport slave  (input TX_SEND, input TX_DATA, output TX_READY);
endinterface

// File: rtl/uart_event_reporter_msg_rom.sv
// Combinational message ROM: welcome and button strings, with the channel
// digit substituted into the button message.
module uart_msg_rom
  import uart_event_reporter_pkg::*;
#(
  parameter int CH_W = 2
) (
  input  msg_sel_t        sel,
  input  logic [4:0]      idx,
  input  logic [CH_W-1:0] ch,
  output logic [7:0]      data
);

  always_comb begin
    data = 8'h00;
    if (sel == SEL_WEL) begin
      if (idx < WELCOME_END) data = WELCOME_ROM[idx];
    end else begin
      if (idx == BTN_DIGIT_IDX)  data = ASCII_0 + 8'(ch);
      else if (idx < BTN_END)    data = BTN_ROM[idx];
    end
  end

endmodule

// File: rtl/uart_event_reporter.sv
// Reports rising edges on debounced event inputs as UART text messages, after
// a power-up guard interval and a welcome string.
//
// state     | meaning
// GUARD     | power-up wait, counting guard_cnt up to GUARD_CYCLES
// LD_WEL    | load welcome string pointers
// SEND_CHAR | strobe TX_SEND with the current byte, advance idx
// RDY_LOW   | one-cycle gap while the transmitter drops READY
// WAIT_RDY  | wait for READY, then next byte or IDLE at string end
// IDLE      | pick next pending channel round-robin from rr_ptr
// LD_BTN    | clear the picked pending bit, load button string pointers
module uart_event_reporter
  import uart_event_reporter_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CH_W         = 2,
  parameter int GUARD_CYCLES = 200000,
  parameter int GUARD_W      = 18
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_CH-1:0]        EVT_I,
  uart_event_reporter_if.master  tx,
  output logic                   BUSY,
  output logic [CH_W-1:0]        CUR_CH,
  output logic                   DROP_PULSE
);

  state_t             state;
  logic [GUARD_W-1:0] guard_cnt;
  msg_sel_t           sel;
  logic [4:0]         idx;
  logic [4:0]         end_idx;
  logic [N_CH-1:0]    evt_prev;
  logic [N_CH-1:0]    pending;
  logic [N_CH-1:0]    edge_v;
  logic [N_CH-1:0]    clr_mask;
  logic [N_CH-1:0]    pending_nxt;
  logic               drop_nxt;
  logic [CH_W-1:0]    rr_ptr;
  logic [CH_W-1:0]    pick_ch;
  logic               pick_vld;
  logic [CH_W-1:0]    rr_nxt;
  logic [CH_W-1:0]    cur_ch_q;
  logic               tx_send_q;
  logic [7:0]         tx_data_q;
  logic               drop_q;
  logic [7:0]         rom_byte;

  uart_msg_rom #(.CH_W(CH_W)) u_rom (
    .sel  (sel),
    .idx  (idx),
    .ch   (cur_ch_q),
    .data (rom_byte)
  );

  // A clear and a fresh edge on the same channel leave the bit set, so the
  // new press still gets its own message and is not counted as a drop.
  always_comb begin
    edge_v      = EVT_I & ~evt_prev;
    clr_mask    = (state == ST_LD_BTN) ? (N_CH'(1) << cur_ch_q) : '0;
    pending_nxt = (pending & ~clr_mask) | edge_v;
    drop_nxt    = |(edge_v & pending & ~clr_mask);
  end

  // Lowest set channel overall covers the wrap; lowest at/above rr_ptr overrides it.
  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (pending[j]) begin
        pick_vld = 1'b1;
        pick_ch  = CH_W'(j);
      end
    end
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (pending[j] && (CH_W'(j) >= rr_ptr)) pick_ch = CH_W'(j);
    end
    rr_nxt = (pick_ch == CH_W'(N_CH - 1)) ? '0 : pick_ch + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_GUARD;
      guard_cnt <= '0;
      sel       <= SEL_WEL;
      idx       <= '0;
      end_idx   <= '0;
      evt_prev  <= EVT_I;
      pending   <= '0;
      rr_ptr    <= '0;
      cur_ch_q  <= '0;
      tx_send_q <= 1'b0;
      tx_data_q <= 8'h00;
      drop_q    <= 1'b0;
    end else begin
      evt_prev  <= EVT_I;
      pending   <= pending_nxt;
      drop_q    <= drop_nxt;
      tx_send_q <= 1'b0;
      case (state)
        ST_GUARD: begin
          if (guard_cnt == GUARD_W'(GUARD_CYCLES)) state <= ST_LD_WEL;
          else guard_cnt <= guard_cnt + 1'b1;
        end
        ST_LD_WEL: begin
          sel     <= SEL_WEL;
          idx     <= '0;
          end_idx <= WELCOME_END;
          state   <= ST_SEND_CHAR;
        end
        ST_SEND_CHAR: begin
          tx_send_q <= 1'b1;
          tx_data_q <= rom_byte;
          idx       <= idx + 5'd1;
          state     <= ST_RDY_LOW;
        end
        ST_RDY_LOW: state <= ST_WAIT_RDY;
        ST_WAIT_RDY: begin
          if (tx.TX_READY) state <= (idx == end_idx) ? ST_IDLE : ST_SEND_CHAR;
        end
        ST_IDLE: begin
          if (pick_vld) begin
            cur_ch_q <= pick_ch;
            rr_ptr   <= rr_nxt;
            state    <= ST_LD_BTN;
          end
        end
        ST_LD_BTN: begin
          sel     <= SEL_BTN;
          idx     <= '0;
          end_idx <= BTN_END;
          state   <= ST_SEND_CHAR;
        end
        default: begin
          state     <= ST_GUARD;
          guard_cnt <= '0;
        end
      endcase
    end
  end

  assign tx.TX_SEND = tx_send_q;
  assign tx.TX_DATA = tx_data_q;
  assign BUSY       = (state != ST_IDLE);
  assign CUR_CH     = cur_ch_q;
  assign DROP_PULSE = drop_q;

endmodule

// File: tb/tb_uart_event_reporter.sv
// Scoreboard bench for uart_event_reporter: stimulus pushes expected bytes,
// a negedge monitor pops and compares every TX_SEND.
module tb_uart_event_reporter;

  localparam int N_CH         = 4;
  localparam int CH_W         = 2;
  localparam int GUARD_CYCLES = 16;
  localparam int GUARD_W      = 5;

  typedef struct {
    logic [7:0]      data;
    logic [CH_W-1:0] ch;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [N_CH-1:0]  EVT_I = '0;
  logic             BUSY;
  logic [CH_W-1:0]  CUR_CH;
  logic             DROP_PULSE;

  uart_event_reporter_if tx_if ();

  uart_event_reporter #(
    .N_CH         (N_CH),
    .CH_W         (CH_W),
    .GUARD_CYCLES (GUARD_CYCLES),
    .GUARD_W      (GUARD_W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EVT_I      (EVT_I),
    .tx         (tx_if.master),
    .BUSY       (BUSY),
    .CUR_CH     (CUR_CH),
    .DROP_PULSE (DROP_PULSE)
  );

  always #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   drops_seen = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Transmitter model: READY low for 10 cycles after each SEND.
  int tx_busy_cnt;
  always @(posedge CLK) begin
    if (RST) begin
      tx_if.TX_READY <= 1'b1;
      tx_busy_cnt    <= 0;
    end else if (tx_if.TX_SEND) begin
      tx_if.TX_READY <= 1'b0;
      tx_busy_cnt    <= 10;
    end else if (tx_busy_cnt > 1) begin
      tx_busy_cnt <= tx_busy_cnt - 1;
    end else if (tx_busy_cnt == 1) begin
      tx_busy_cnt    <= 0;
      tx_if.TX_READY <= 1'b1;
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (DROP_PULSE) drops_seen++;
      if (tx_if.TX_SEND) begin
        check("send_while_ready", 32'(tx_if.TX_READY), 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_byte: got %02h, no byte expected", tx_if.TX_DATA);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", 32'(tx_if.TX_DATA), 32'(e.data));
          check("cur_ch", 32'(CUR_CH), 32'(e.ch));
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_str(input string s, input int ch);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.data = s[i];
      e.ch   = CH_W'(ch);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_welcome();
    string w;
    w = "\n\rARTY GPIO/UART DEMO!      \n\n\r";
    push_str(w, 0);
  endtask

  task automatic push_btn(input int ch);
    push_str($sformatf("Button %0d pressed!\n\r", ch), ch);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !BUSY) && n < 3000) begin
      tick();
      n++;
    end
    check(name, 32'(n < 3000), 32'd1);
  endtask

  task automatic count_to_send(output int n, input int lim);
    n = 0;
    do begin
      tick();
      n++;
    end while (!tx_if.TX_SEND && n < lim);
  endtask

  initial begin
    int n;
    RST   = 1'b1;
    EVT_I = '0;
    repeat (3) tick();
    check("rst_tx_send", 32'(tx_if.TX_SEND), 32'd0);
    check("rst_tx_data", 32'(tx_if.TX_DATA), 32'h00);
    check("rst_busy", 32'(BUSY), 32'd1);
    check("rst_cur_ch", 32'(CUR_CH), 32'd0);
    check("rst_drop", 32'(DROP_PULSE), 32'd0);

    // Welcome after guard, with a ch1 press landing mid-welcome
    push_welcome();
    RST = 1'b0;
    count_to_send(n, 40);
    check("guard_len", 32'(n >= 17 && n <= 21), 32'd1);
    repeat (60) tick();
    EVT_I[1] = 1'b1;
    push_btn(1);
    repeat (3) tick();
    EVT_I[1] = 1'b0;
    wait_idle("welcome_then_ch1");

    // Single press latency from IDLE
    EVT_I[2] = 1'b1;
    push_btn(2);
    count_to_send(n, 20);
    check("evt_latency", 32'(n), 32'd4);
    EVT_I[2] = 1'b0;
    wait_idle("ch2_msg");
    repeat (30) tick();
    check("idle_after_ch2", 32'(BUSY), 32'd0);

    // ch3 alone wraps rr_ptr to 0
    EVT_I[3] = 1'b1;
    push_btn(3);
    repeat (3) tick();
    EVT_I[3] = 1'b0;
    wait_idle("ch3_msg");

    // Simultaneous ch0 and ch3 with rr_ptr = 0
    EVT_I[0] = 1'b1;
    EVT_I[3] = 1'b1;
    push_btn(0);
    push_btn(3);
    repeat (3) tick();
    EVT_I = '0;
    wait_idle("ch0_ch3_msgs");

    // ch1 re-pressed twice while its message is in flight
    EVT_I[1] = 1'b1;
    push_btn(1);
    repeat (3) tick();
    EVT_I[1] = 1'b0;
    repeat (40) tick();
    EVT_I[1] = 1'b1;
    push_btn(1);
    tick();
    check("no_drop_first_repress", 32'(DROP_PULSE), 32'd0);
    tick();
    EVT_I[1] = 1'b0;
    repeat (2) tick();
    EVT_I[1] = 1'b1;
    tick();
    check("drop_pulse", 32'(DROP_PULSE), 32'd1);
    tick();
    check("drop_one_cycle", 32'(DROP_PULSE), 32'd0);
    EVT_I[1] = 1'b0;
    wait_idle("ch1_twice");

    // Reset mid ch2 message with ch0 pending and ch3 held high across reset
    EVT_I[2] = 1'b1;
    push_btn(2);
    repeat (3) tick();
    EVT_I[2] = 1'b0;
    repeat (50) tick();
    EVT_I[0] = 1'b1;
    tick();
    EVT_I[0] = 1'b0;
    count_to_send(n, 30);
    check("send_before_rst", 32'(tx_if.TX_SEND), 32'd1);
    tick();
    RST      = 1'b1;
    EVT_I[3] = 1'b1;
    exp_q.delete();
    tick();
    check("rst_mid_tx_send", 32'(tx_if.TX_SEND), 32'd0);
    check("rst_mid_busy", 32'(BUSY), 32'd1);
    check("rst_mid_cur_ch", 32'(CUR_CH), 32'd0);
    RST = 1'b0;
    push_welcome();
    count_to_send(n, 40);
    check("guard_len_again", 32'(n >= 17 && n <= 21), 32'd1);
    wait_idle("welcome_resent");
    repeat (40) tick();
    check("no_msg_after_rst", 32'(BUSY), 32'd0);
    EVT_I[3] = 1'b0;
    repeat (5) tick();

    check("drop_count", 32'(drops_seen), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
